// File: rtl/mul_shift_add_ctrl.sv
// Sequential shift-add unsigned multiplier with a start/busy/done/ack handshake.
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_shift_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CW-1:0]      cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // P is only cleared on acceptance, so the last product stays visible while idle
          if (start) begin
            a_q   <= {{WIDTH{1'b0}}, a_in};
            b_q   <= b_in;
            p_q   <= '0;
            cnt   <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
`ifdef MUL_EARLY_EXIT_EN
          if (b_q == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else
`endif
          begin
            if (b_q[0]) p_q <= p_q + a_q;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign product = p_q;

endmodule
